// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the R-type sequencer: FSM states, ALU op codes, FUNCT values.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // ALU operation select, shared with the ALU
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SUBU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;

endpackage

// File: rtl/rtype_decode.sv
// Combinational R-type decoder: FUNCT to ALU op, legality, and signed-overflow trap class.
module rtype_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       legal_o,
    output logic       signed_ovf_o
);

    logic fn_ok;

    always_comb begin
        alu_op_o = ALU_ADD;
        fn_ok    = 1'b1;
        case (funct_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_ADDU: alu_op_o = ALU_ADDU;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_SUBU: alu_op_o = ALU_SUBU;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_XOR:  alu_op_o = ALU_XOR;
            FN_NOR:  alu_op_o = ALU_NOR;
            FN_SLT:  alu_op_o = ALU_SLT;
            FN_SLTU: alu_op_o = ALU_SLTU;
            FN_SLL:  alu_op_o = ALU_SLL;
            FN_SRL:  alu_op_o = ALU_SRL;
            FN_SRA:  alu_op_o = ALU_SRA;
            default: fn_ok    = 1'b0;
        endcase
    end

    assign legal_o      = (opcode_i == OP_RTYPE) && fn_ok;
    // Only the trapping signed forms suppress the register write on overflow
    assign signed_ovf_o = legal_o && ((funct_i == FN_ADD) || (funct_i == FN_SUB));

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/WB sequencer with free-run/single-step control,
// sticky illegal-instruction halt and a wrapping retired-instruction counter.
module cpu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [5:0]       OPCODE,
    input  logic [5:0]       FUNCT,
    input  logic             ALU_ZF,
    input  logic             ALU_OF,
    output logic             IR_WE,
    output logic             PC_WE,
    output logic             RF_WE,
    output logic             FLAG_WE,
    output logic [3:0]       ALU_OP,
    output logic             BUSY,
    output logic             ILLEGAL,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] INSTR_CNT
);

    state_e             state_q, state_d;
    logic               step_q;
    logic               of_q;
    logic               trap_q;
    logic               illegal_q;
    logic [3:0]         alu_op_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               step_edge;
    logic [3:0]         dec_op;
    logic               dec_legal;
    logic               dec_sovf;

    // Zero flag goes straight to the flag register; sequencing never looks at it
    logic               unused_zf;
    assign unused_zf = ALU_ZF;

    rtype_decode u_dec (
        .opcode_i     (OPCODE),
        .funct_i      (FUNCT),
        .alu_op_o     (dec_op),
        .legal_o      (dec_legal),
        .signed_ovf_o (dec_sovf)
    );

    assign step_edge = STEP & ~step_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            step_q    <= 1'b0;
            of_q      <= 1'b0;
            trap_q    <= 1'b0;
            illegal_q <= 1'b0;
            alu_op_q  <= ALU_ADD;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= STEP;
            if (state_q == ST_DECODE) begin
                alu_op_q <= dec_op;
                trap_q   <= dec_sovf;
                if (!dec_legal) illegal_q <= 1'b1;
            end
            if (state_q == ST_EXEC) of_q <= ALU_OF;
            if (state_q == ST_WB)   cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (RUN || step_edge) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_HALT;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = RUN ? ST_FETCH : ST_IDLE;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        IR_WE   = 1'b0;
        PC_WE   = 1'b0;
        RF_WE   = 1'b0;
        FLAG_WE = 1'b0;
        BUSY    = 1'b1;
        case (state_q)
            ST_FETCH: IR_WE   = 1'b1;
            ST_EXEC:  FLAG_WE = 1'b1;
            ST_WB: begin
                PC_WE = 1'b1;
                RF_WE = ~(trap_q & of_q);
            end
            ST_IDLE, ST_HALT: BUSY = 1'b0;
            default: ;
        endcase
    end

    assign ALU_OP    = alu_op_q;
    assign ILLEGAL   = illegal_q;
    assign STATE     = state_q;
    assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: directed scenarios plus random stimulus against an
// instruction-level reference model (phase counter, FUNCT table, retire count).
module tb_cpu_seq_ctrl;

    logic        CLK, RST, RUN, STEP, ALU_ZF, ALU_OF;
    logic [5:0]  OPCODE, FUNCT;

    logic        IR_WE, PC_WE, RF_WE, FLAG_WE, BUSY, ILLEGAL;
    logic [3:0]  ALU_OP;
    logic [2:0]  STATE;
    logic [15:0] INSTR_CNT;

    logic        IR_WE4, PC_WE4, RF_WE4, FLAG_WE4, BUSY4, ILLEGAL4;
    logic [3:0]  ALU_OP4;
    logic [2:0]  STATE4;
    logic [3:0]  INSTR_CNT4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] legal_fn [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                  6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

    cpu_seq_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .ALU_ZF(ALU_ZF), .ALU_OF(ALU_OF), .IR_WE(IR_WE), .PC_WE(PC_WE), .RF_WE(RF_WE),
        .FLAG_WE(FLAG_WE), .ALU_OP(ALU_OP), .BUSY(BUSY), .ILLEGAL(ILLEGAL),
        .STATE(STATE), .INSTR_CNT(INSTR_CNT)
    );

    cpu_seq_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .ALU_ZF(ALU_ZF), .ALU_OF(ALU_OF), .IR_WE(IR_WE4), .PC_WE(PC_WE4), .RF_WE(RF_WE4),
        .FLAG_WE(FLAG_WE4), .ALU_OP(ALU_OP4), .BUSY(BUSY4), .ILLEGAL(ILLEGAL4),
        .STATE(STATE4), .INSTR_CNT(INSTR_CNT4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference model: mode 0=idle 1=running an instruction 2=halted; phase 0..3 within it
    int m_mode, m_phase, m_op, m_cnt;
    bit m_step_prev, m_ill, m_of, m_trap;

    function automatic int fn_op(input logic [5:0] f);
        case (f)
            6'h20: return 0;  6'h21: return 1;  6'h22: return 2;  6'h23: return 3;
            6'h24: return 4;  6'h25: return 5;  6'h26: return 6;  6'h27: return 7;
            6'h2A: return 8;  6'h2B: return 9;  6'h00: return 10; 6'h02: return 11;
            6'h03: return 12;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_op = 0; m_cnt = 0;
        m_step_prev = 0; m_ill = 0; m_of = 0; m_trap = 0;
    endtask

    task automatic model_update();
        bit edge_seen;
        int k;
        if (!RST) begin
            model_reset();
            return;
        end
        edge_seen   = STEP && !m_step_prev;
        m_step_prev = STEP;
        if (m_mode == 0) begin
            if (RUN || edge_seen) begin m_mode = 1; m_phase = 0; end
        end else if (m_mode == 1) begin
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    k = fn_op(FUNCT);
                    if (OPCODE == 6'h00 && k >= 0) begin
                        m_op = k; m_trap = (k == 0 || k == 2); m_phase = 2;
                    end else begin
                        m_mode = 2; m_ill = 1;
                    end
                end
                2: begin m_of = ALU_OF; m_phase = 3; end
                default: begin
                    m_cnt++;
                    if (RUN) m_phase = 0; else m_mode = 0;
                end
            endcase
        end
    endtask

    // Expected outputs of both instances; ALU_OP is left unconstrained while halted
    function automatic logic [45:0] exp_vec();
        logic [2:0] st;
        logic ir, pc, rf, fl, bz;
        logic [3:0] op;
        st = (m_mode == 0) ? 3'd0 : (m_mode == 2) ? 3'd5 : 3'(m_phase + 1);
        ir = (m_mode == 1) && (m_phase == 0);
        fl = (m_mode == 1) && (m_phase == 2);
        pc = (m_mode == 1) && (m_phase == 3);
        rf = pc && !(m_trap && m_of);
        bz = (m_mode == 1);
        op = (m_mode == 2) ? 4'd0 : 4'(m_op);
        return {st, ir, pc, rf, fl, op, bz, m_ill, 16'(m_cnt),
                st, ir, pc, rf, fl, op, bz, m_ill, 4'(m_cnt)};
    endfunction

    function automatic logic [45:0] obs_vec();
        return {STATE, IR_WE, PC_WE, RF_WE, FLAG_WE, (m_mode == 2) ? 4'd0 : ALU_OP,
                BUSY, ILLEGAL, INSTR_CNT,
                STATE4, IR_WE4, PC_WE4, RF_WE4, FLAG_WE4, (m_mode == 2) ? 4'd0 : ALU_OP4,
                BUSY4, ILLEGAL4, INSTR_CNT4};
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        model_reset();
        RUN = 1'($urandom); STEP = 1'($urandom); OPCODE = 6'($urandom);
        FUNCT = 6'($urandom); ALU_OF = 1'($urandom); ALU_ZF = 1'($urandom);
        tick();
        RUN = 1'b0; STEP = 1'b0; OPCODE = 6'h00; ALU_OF = 1'b0;
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            RUN = 1'($urandom); STEP = 1'($urandom); OPCODE = 6'($urandom);
            FUNCT = 6'($urandom); ALU_OF = 1'($urandom); ALU_ZF = 1'($urandom);
            tick();
            n_tests++;
            if (obs_vec() !== 46'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %h want 0", c, obs_vec());
            end
        end
        // STEP already high at release counts as an edge
        RUN = 1'b0; STEP = 1'b1; OPCODE = 6'h00; FUNCT = 6'h20;
        RST = 1'b1;
        tick();
        n_tests++;
        if (STATE !== 3'd1 || IR_WE !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_step_high: got state %0d vec %h want state 1 vec %h",
                     STATE, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        RUN = 1'b1; FUNCT = legal_fn[$urandom_range(0, 12)];
        for (int c = 0; c < 11; c++) tick();
        n_tests++;
        if (STATE !== 3'd3 || INSTR_CNT !== 16'd2) begin
            n_fail++;
            $display("FAIL mid_exec_setup: got state %0d cnt %0d want 3 2", STATE, INSTR_CNT);
        end
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (STATE !== 3'd0 || INSTR_CNT !== 16'd0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL mid_exec_reset: got state %0d cnt %0d want 0 0", STATE, INSTR_CNT);
        end
        tick();
        RST = 1'b1;
    endtask

    task automatic test_single_step();
        do_reset();
        RUN = 1'b0; OPCODE = 6'h00; FUNCT = 6'h20; ALU_OF = 1'b0; STEP = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_step cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 1) begin
                n_tests++;
                if (IR_WE !== 1'b1) begin
                    n_fail++; $display("FAIL step_ir_we: got %b want 1", IR_WE);
                end
            end
            if (c == 3) begin
                n_tests++;
                if (FLAG_WE !== 1'b1 || ALU_OP !== 4'd0) begin
                    n_fail++; $display("FAIL step_exec: got flag %b op %0d want 1 0", FLAG_WE, ALU_OP);
                end
            end
            if (c == 4) begin
                n_tests++;
                if (RF_WE !== 1'b1 || PC_WE !== 1'b1) begin
                    n_fail++; $display("FAIL step_wb: got rf %b pc %b want 1 1", RF_WE, PC_WE);
                end
            end
            if (c == 10) begin
                n_tests++;
                if (STATE !== 3'd0 || INSTR_CNT !== 16'd1) begin
                    n_fail++; $display("FAIL step_once: got state %0d cnt %0d want 0 1", STATE, INSTR_CNT);
                end
            end
        end
    endtask

    task automatic test_free_run();
        bool_wait: begin end
        do_reset();
        RUN = 1'b1; OPCODE = 6'h00; FUNCT = 6'h25;
        for (int c = 1; c <= 13; c++) begin
            ALU_OF = 1'($urandom);
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec() || BUSY !== 1'b1) begin
                n_fail++;
                $display("FAIL free_run cyc%0d: got %h busy %b want %h busy 1", c, obs_vec(), BUSY, exp_vec());
            end
        end
        n_tests++;
        if (INSTR_CNT !== 16'd3 || ALU_OP !== 4'd5) begin
            n_fail++; $display("FAIL free_run_total: got cnt %0d op %0d want 3 5", INSTR_CNT, ALU_OP);
        end
        for (int c = 0; c < 8 && STATE !== 3'd2; c++) tick();
        n_tests++;
        if (STATE !== 3'd2) begin
            n_fail++; $display("FAIL free_run_decode_wait: got state %0d want 2", STATE);
        end
        RUN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL run_drop cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (STATE !== 3'd0 || INSTR_CNT !== 16'd4) begin
            n_fail++; $display("FAIL run_drop_idle: got state %0d cnt %0d want 0 4", STATE, INSTR_CNT);
        end
    endtask

    task automatic test_overflow();
        logic [5:0] fns [2] = '{6'h22, 6'h23};
        do_reset();
        RUN = 1'b0; ALU_OF = 1'b1;
        for (int i = 0; i < 2; i++) begin
            FUNCT = fns[i]; STEP = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                tick();
                n_tests++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++; $display("FAIL overflow%0d cyc%0d: got %h want %h", i, c, obs_vec(), exp_vec());
                end
                if (c == 3) begin
                    n_tests++;
                    if (FLAG_WE !== 1'b1) begin
                        n_fail++; $display("FAIL ovf_flag_we%0d: got %b want 1", i, FLAG_WE);
                    end
                end
            end
            n_tests++;
            if (PC_WE !== 1'b1 || RF_WE !== (i == 1)) begin
                n_fail++; $display("FAIL ovf_wb%0d: got pc %b rf %b want 1 %0d", i, PC_WE, RF_WE, i);
            end
            STEP = 1'b0;
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [5:0] opcs [2] = '{6'h00, 6'h08};
        logic [5:0] fns  [2] = '{6'h3F, 6'h20};
        for (int i = 0; i < 2; i++) begin
            do_reset();
            RUN = 1'b0; OPCODE = opcs[i]; FUNCT = fns[i]; STEP = 1'b1;
            tick(); tick(); tick();
            RUN = 1'b1;
            for (int c = 0; c < 10; c++) begin
                STEP = ~STEP;
                tick();
                n_tests++;
                if (STATE !== 3'd5 || ILLEGAL !== 1'b1 || BUSY !== 1'b0 || RF_WE !== 1'b0 ||
                    PC_WE !== 1'b0 || IR_WE !== 1'b0 || FLAG_WE !== 1'b0 || obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL illegal%0d cyc%0d: got state %0d ill %b busy %b rf %b pc %b want 5 1 0 0 0",
                             i, c, STATE, ILLEGAL, BUSY, RF_WE, PC_WE);
                end
            end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        RUN = 1'b1; OPCODE = 6'h00; FUNCT = 6'h21; ALU_OF = 1'b0;
        for (int c = 1; c <= 69; c++) begin
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL wrap cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 61 || c == 65 || c == 69) begin
                n_tests++;
                if (INSTR_CNT4 !== ((c == 61) ? 4'd15 : (c == 65) ? 4'd0 : 4'd1)) begin
                    n_fail++; $display("FAIL wrap_cnt cyc%0d: got %0d", c, INSTR_CNT4);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                RST = 1'b0;
                model_reset();
            end else begin
                RST = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) RUN = ~RUN;
            if ($urandom_range(0, 2) == 0) STEP = ~STEP;
            OPCODE = ($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'h00;
            FUNCT  = ($urandom_range(0, 19) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 12)];
            ALU_OF = 1'($urandom);
            ALU_ZF = 1'($urandom);
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        RST = 1'b1;
    endtask

    initial begin
        RST = 1'b0; RUN = 1'b0; STEP = 1'b0; OPCODE = 6'h00; FUNCT = 6'h00;
        ALU_OF = 1'b0; ALU_ZF = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_reset_mid_exec();
        test_single_step();
        test_free_run();
        test_overflow();
        test_illegal();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
